// File: rtl/phase_accumulator.sv
// ---------------------------------------------------------------------------
// phase_accumulator
// Modulo phase accumulator with up/down/ping-pong/hold modes, synchronous
// clear/load and a programmable modulus (limit+1). NUM_CH offset channels
// derive registered waveform-ROM addresses from the shared phase.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        advance enable
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val (clamped to limit)
//   load_val  load value
//   mode      00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD
//   incr      phase step per enabled cycle
//   limit     maximum phase value
//   offset    packed per-channel offsets, channel i at [i*WIDTH +: WIDTH]
//   count     accumulator phase
//   ch_addr   packed per-channel addresses, one cycle behind count
//   wrap      one-cycle pulse on wrap or ping-pong turnaround
//   dir       ping-pong direction, 0 = up, 1 = down
// ---------------------------------------------------------------------------
module phase_accumulator #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        incr,
  input  logic [WIDTH-1:0]        limit,
  input  logic [NUM_CH*WIDTH-1:0] offset,
  output logic [WIDTH-1:0]        count,
  output logic [NUM_CH*WIDTH-1:0] ch_addr,
  output logic                    wrap,
  output logic                    dir
);

  localparam int unsigned WP1 = WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [WIDTH-1:0]        r_count;
  logic [NUM_CH*WIDTH-1:0] r_ch_addr;
  logic                    r_wrap;
  logic                    r_dir;

  logic [WIDTH-1:0]        w_count_nxt;
  logic [NUM_CH*WIDTH-1:0] w_ch_nxt;
  logic                    w_wrap_nxt;
  logic                    w_dir_nxt;

  logic [WP1-1:0]          w_lim_ext;
  logic [WP1-1:0]          w_sum;
  logic [WP1-1:0]          w_down_wrap;

  // Single modulus correction, then forced to 0 if still out of range.
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [WP1-1:0] t,
                                                  input logic [WP1-1:0] lim);
    logic [WP1-1:0] corr;
    corr = t - lim - WP1'(1);
    if (t <= lim)         mod_reduce = t[WIDTH-1:0];
    else if (corr <= lim) mod_reduce = corr[WIDTH-1:0];
    else                  mod_reduce = '0;
  endfunction

  // Shared arithmetic, all at WIDTH+1 bits.
  always_comb begin
    w_lim_ext   = {1'b0, limit};
    w_sum       = {1'b0, r_count} + {1'b0, incr};
    w_down_wrap = {1'b0, r_count} + w_lim_ext + WP1'(1) - {1'b0, incr};
  end

  // Next-state for phase, direction and wrap pulse (clr > load > en).
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    if (clr) begin
      w_count_nxt = '0;
      w_dir_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = (load_val > limit) ? limit : load_val;
      w_dir_nxt   = 1'b0;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          w_count_nxt = mod_reduce(w_sum, w_lim_ext);
          w_wrap_nxt  = (w_sum > w_lim_ext);
        end
        MODE_DOWN: begin
          if (r_count >= incr) begin
            w_count_nxt = r_count - incr;
          end else begin
            // Underflow wraps by one modulus; anything still beyond limit is zeroed.
            w_count_nxt = (w_down_wrap > w_lim_ext) ? '0 : w_down_wrap[WIDTH-1:0];
            w_wrap_nxt  = 1'b1;
          end
        end
        MODE_PP: begin
          // Clamp at the ends rather than reflecting the overshoot.
          if (!r_dir) begin
            if (w_sum >= w_lim_ext) begin
              w_count_nxt = limit;
              w_dir_nxt   = 1'b1;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_count_nxt = w_sum[WIDTH-1:0];
            end
          end else begin
            if (r_count <= incr) begin
              w_count_nxt = '0;
              w_dir_nxt   = 1'b0;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_count_nxt = r_count - incr;
            end
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // Per-channel address from the current registered phase plus offset.
  always_comb begin
    w_ch_nxt = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_ch_nxt[i*WIDTH +: WIDTH] =
        mod_reduce({1'b0, r_count} + {1'b0, offset[i*WIDTH +: WIDTH]}, w_lim_ext);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_ch_addr <= '0;
      r_wrap    <= 1'b0;
      r_dir     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_ch_addr <= w_ch_nxt;
      r_wrap    <= w_wrap_nxt;
      r_dir     <= w_dir_nxt;
    end
  end

  assign count   = r_count;
  assign ch_addr = r_ch_addr;
  assign wrap    = r_wrap;
  assign dir     = r_dir;

endmodule

// File: tb/tb_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_phase_accumulator
// Directed bench for phase_accumulator (WIDTH=8, NUM_CH=2). Expected values
// are queued when a step is driven and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_phase_accumulator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_CH = 2;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    clr;
  logic                    load;
  logic [WIDTH-1:0]        load_val;
  logic [1:0]              mode;
  logic [WIDTH-1:0]        incr;
  logic [WIDTH-1:0]        limit;
  logic [NUM_CH*WIDTH-1:0] offset;
  logic [WIDTH-1:0]        count;
  logic [NUM_CH*WIDTH-1:0] ch_addr;
  logic                    wrap;
  logic                    dir;

  typedef struct {
    string                   tag;
    logic [WIDTH-1:0]        cnt;
    logic                    wrp;
    logic                    dr;
    bit                      chk_ch;
    logic [NUM_CH*WIDTH-1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  phase_accumulator #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .incr     (incr),
    .limit    (limit),
    .offset   (offset),
    .count    (count),
    .ch_addr  (ch_addr),
    .wrap     (wrap),
    .dir      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare current outputs against the oldest queued expectation.
  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (count === e.cnt) else begin
      failures++;
      $error("FAIL %s.count: got %0d expected %0d", e.tag, count, e.cnt);
    end
    checks++;
    assert (wrap === e.wrp) else begin
      failures++;
      $error("FAIL %s.wrap: got %0b expected %0b", e.tag, wrap, e.wrp);
    end
    checks++;
    assert (dir === e.dr) else begin
      failures++;
      $error("FAIL %s.dir: got %0b expected %0b", e.tag, dir, e.dr);
    end
    if (e.chk_ch) begin
      checks++;
      assert (ch_addr === e.ch) else begin
        failures++;
        $error("FAIL %s.ch_addr: got %h expected %h", e.tag, ch_addr, e.ch);
      end
    end
  endtask

  // Queue expectation, clock once, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [WIDTH-1:0] c,
                      input logic w, input logic d,
                      input bit chk_ch = 1'b0,
                      input logic [NUM_CH*WIDTH-1:0] ch = '0);
    exp_t e;
    e.tag = tag; e.cnt = c; e.wrp = w; e.dr = d; e.chk_ch = chk_ch; e.ch = ch;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic set_ctl(input logic c, input logic l, input logic e);
    clr = c; load = l; en = e;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    mode = 2'b00; incr = 8'd1; limit = 8'd255; offset = '0;

    // Reset state
    #12;
    begin
      exp_t e;
      e.tag = "reset"; e.cnt = 0; e.wrp = 0; e.dr = 0; e.chk_ch = 1; e.ch = '0;
      sb.push_back(e);
      check_front();
    end
    @(negedge clk);
    rst = 1'b1;

    // 1. Count up to 37, then asynchronous reset mid-cycle
    set_ctl(0, 0, 1);
    for (int i = 1; i <= 37; i++) step("up37", 8'(i), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    begin
      exp_t e;
      e.tag = "async_rst"; e.cnt = 0; e.wrp = 0; e.dr = 0; e.chk_ch = 1; e.ch = '0;
      sb.push_back(e);
      check_front();
    end
    #1 rst = 1'b1;
    step("resume", 8'd1, 1'b0, 1'b0);

    // 2. UP modulo 10, step 3
    set_ctl(1, 0, 0);
    step("clr", 8'd0, 1'b0, 1'b0);
    set_ctl(0, 0, 1); limit = 8'd9; incr = 8'd3;
    step("up_a", 8'd3, 1'b0, 1'b0);
    step("up_b", 8'd6, 1'b0, 1'b0);
    step("up_c", 8'd9, 1'b0, 1'b0);
    step("up_wrap", 8'd2, 1'b1, 1'b0);
    step("up_e", 8'd5, 1'b0, 1'b0);

    // 3. DOWN with underflow wrap
    limit = 8'd255; incr = 8'd16; mode = 2'b01; load_val = 8'd8;
    set_ctl(0, 1, 0);
    step("dn_load", 8'd8, 1'b0, 1'b0);
    set_ctl(0, 0, 1);
    step("dn_wrap", 8'd248, 1'b1, 1'b0);
    step("dn_b", 8'd232, 1'b0, 1'b0);

    // 4. PINGPONG clamp and turnaround
    set_ctl(1, 0, 0);
    step("pp_clr", 8'd0, 1'b0, 1'b0);
    set_ctl(0, 0, 1); limit = 8'd10; incr = 8'd4; mode = 2'b10;
    step("pp_a", 8'd4, 1'b0, 1'b0);
    step("pp_b", 8'd8, 1'b0, 1'b0);
    step("pp_top", 8'd10, 1'b1, 1'b1);
    step("pp_d", 8'd6, 1'b0, 1'b1);
    step("pp_e", 8'd2, 1'b0, 1'b1);
    step("pp_bot", 8'd0, 1'b1, 1'b0);
    step("pp_g", 8'd4, 1'b0, 1'b0);

    // 5. Channel offsets, including an offset beyond limit
    limit = 8'd9; mode = 2'b00; offset = {8'd5, 8'd0}; load_val = 8'd7;
    set_ctl(0, 1, 0);
    step("ofs_load", 8'd7, 1'b0, 1'b0);
    set_ctl(0, 0, 0);
    step("ofs_a", 8'd7, 1'b0, 1'b0, 1'b1, {8'd2, 8'd7});
    offset = {8'd15, 8'd0};
    step("ofs_big", 8'd7, 1'b0, 1'b0, 1'b1, {8'd0, 8'd7});

    // 6. Priority clr > load > en, and load clamp
    limit = 8'd99; incr = 8'd1; load_val = 8'd50;
    set_ctl(1, 1, 1);
    step("prio_clr", 8'd0, 1'b0, 1'b0);
    set_ctl(0, 1, 1);
    step("prio_load", 8'd50, 1'b0, 1'b0);
    load_val = 8'd200;
    step("load_clamp", 8'd99, 1'b0, 1'b0);

    // limit=0: always 0 with wrap on each enabled UP step
    set_ctl(0, 0, 1); limit = 8'd0;
    step("lim0_a", 8'd0, 1'b1, 1'b0);
    step("lim0_b", 8'd0, 1'b1, 1'b0);
    mode = 2'b11;
    step("hold", 8'd0, 1'b0, 1'b0);

    // incr > limit: one correction then zeroed
    limit = 8'd9; incr = 8'd25; mode = 2'b00; load_val = 8'd3;
    set_ctl(0, 1, 0);
    step("big_load", 8'd3, 1'b0, 1'b0);
    set_ctl(0, 0, 1);
    step("big_incr", 8'd0, 1'b1, 1'b0);

    // Natural binary wrap at limit=255
    limit = 8'd255; incr = 8'd10; load_val = 8'd250;
    set_ctl(0, 1, 0);
    step("nat_load", 8'd250, 1'b0, 1'b0);
    set_ctl(0, 0, 1);
    step("nat_wrap", 8'd4, 1'b1, 1'b0);

    // PINGPONG with incr=0 at limit still turns around
    limit = 8'd10; incr = 8'd0; load_val = 8'd10;
    set_ctl(0, 1, 0);
    step("pp0_load", 8'd10, 1'b0, 1'b0);
    set_ctl(0, 0, 1); mode = 2'b10;
    step("pp0_turn", 8'd10, 1'b1, 1'b1);
    step("pp0_stay", 8'd10, 1'b0, 1'b1);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout guard
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
